// File: rtl/digit_grid_sampler.sv
// Box-averages an 11x11-cell ROI raster stream into an 8-bit digit grid that is published atomically.
// grid_valid pulses one cycle after the last accepted pixel; pix_valid gaps are transparent.
module digit_grid_sampler #(
  parameter int CELL_W_LOG2 = 2,
  parameter int CELL_H_LOG2 = 2,
  parameter bit INVERT      = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pix_valid,
  input  logic                   pix_sof,
  input  logic [7:0]             pix_data,
  output logic                   busy,
  output logic                   grid_valid,
  output logic [10:0][10:0][7:0] numero
);
  localparam int W     = 1 << CELL_W_LOG2;
  localparam int H     = 1 << CELL_H_LOG2;
  localparam int ROI_W = 11 * W;
  localparam int ROI_H = 11 * H;
  localparam int XW    = CELL_W_LOG2 + 4;
  localparam int YW    = CELL_H_LOG2 + 4;
  localparam int SH    = CELL_W_LOG2 + CELL_H_LOG2;
  localparam int AW    = 8 + SH;

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACCUM} state_t;

  state_t                 r_state;
  logic [XW-1:0]          r_x;
  logic [YW-1:0]          r_y;
  logic [AW-1:0]          r_acc [11];
  logic [10:0][10:0][7:0] r_shadow;

  logic          w_restart;
  logic          w_take;
  logic [XW-1:0] w_px;
  logic [YW-1:0] w_py;
  logic [3:0]    w_col;
  logic [3:0]    w_row;
  logic [7:0]    w_pix;
  logic          w_cell_end;
  logic          w_frame_end;
  logic [AW-1:0] w_sum;
  logic [7:0]    w_avg;

  // A sof pixel seen while waiting or mid-frame becomes (0,0) of a fresh frame.
  always_comb begin
    w_restart   = pix_valid && pix_sof && (r_state != IDLE);
    w_take      = (pix_valid && (r_state == ACCUM)) || w_restart;
    w_px        = w_restart ? '0 : r_x;
    w_py        = w_restart ? '0 : r_y;
    w_col       = w_px[XW-1:CELL_W_LOG2];
    w_row       = w_py[YW-1:CELL_H_LOG2];
    w_pix       = INVERT ? (8'd255 - pix_data) : pix_data;
    w_cell_end  = ((w_px & XW'(W - 1)) == XW'(W - 1)) && ((w_py & YW'(H - 1)) == YW'(H - 1));
    w_frame_end = (w_px == XW'(ROI_W - 1)) && (w_py == YW'(ROI_H - 1));
    w_sum       = (w_restart ? '0 : r_acc[w_col]) + AW'(w_pix);
    w_avg       = 8'(w_sum >> SH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_shadow   <= '0;
      numero     <= '0;
      busy       <= 1'b0;
      grid_valid <= 1'b0;
      for (int c = 0; c < 11; c++) r_acc[c] <= '0;
    end else begin
      grid_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= WAIT_SOF;
            busy    <= 1'b1;
          end
        end
        default: begin
          if (w_take) begin
            if (w_restart) begin
              for (int c = 0; c < 11; c++) r_acc[c] <= '0;
            end
            if (w_cell_end) begin
              r_acc[w_col]           <= '0;
              r_shadow[w_row][w_col] <= w_avg;
            end else begin
              r_acc[w_col] <= w_sum;
            end
            if (w_frame_end) begin
              // The final cell is still in flight to the shadow, so merge it directly.
              numero               <= r_shadow;
              numero[w_row][w_col] <= w_avg;
              grid_valid           <= 1'b1;
              busy                 <= 1'b0;
              r_state              <= IDLE;
              r_x                  <= '0;
              r_y                  <= '0;
            end else begin
              r_state <= ACCUM;
              if (w_px == XW'(ROI_W - 1)) begin
                r_x <= '0;
                r_y <= w_py + 1'b1;
              end else begin
                r_x <= w_px + 1'b1;
                r_y <= w_py;
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_digit_grid_sampler.sv
// Directed bench: two samplers (plain and inverting) share one pixel stream; grids are checked against hand-derived cell values.
`timescale 1ns/1ps
module tb_digit_grid_sampler;
  logic clock = 1'b0;
  logic reset, start, pix_valid, pix_sof;
  logic [7:0] pix_data;
  logic busy0, gv0, busy1, gv1;
  logic [10:0][10:0][7:0] num0, num1;

  int n_assert = 0;
  int n_fail   = 0;
  int gv_count = 0;
  int cval     = 0;
  int gv_mark  = 0;
  logic [7:0] prev37 = 8'd0;

  digit_grid_sampler #(.CELL_W_LOG2(2), .CELL_H_LOG2(2), .INVERT(1'b0)) u0 (
    .clock(clock), .reset(reset), .start(start), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_data(pix_data), .busy(busy0), .grid_valid(gv0), .numero(num0));

  digit_grid_sampler #(.CELL_W_LOG2(2), .CELL_H_LOG2(2), .INVERT(1'b1)) u1 (
    .clock(clock), .reset(reset), .start(start), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_data(pix_data), .busy(busy1), .grid_valid(gv1), .numero(num1));

  always #5 clock = ~clock;

  always @(negedge clock) if (gv0 === 1'b1) gv_count++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: constant cval, 1: cell pattern 10*row+col, 2: truncation frame, 3: all-zero grid
  function automatic int pix_val(input int mode, input int x, input int y);
    int r, c;
    r = y / 4;
    c = x / 4;
    case (mode)
      0: return cval;
      1: return 10 * r + c;
      default: begin
        if (r == 0 && c == 0) return (x == 0 && y == 0) ? 1 : 0;
        if (r == 0 && c == 1) return 0;
        return 55;
      end
    endcase
  endfunction

  function automatic int exp_cell(input int mode, input bit inv, input int r, input int c);
    int v;
    case (mode)
      0: v = cval;
      1: v = 10 * r + c;
      2: begin
        if (r == 0 && c == 0) return inv ? 254 : 0;
        if (r == 0 && c == 1) return inv ? 255 : 0;
        v = 55;
      end
      default: return 0;
    endcase
    return inv ? 255 - v : v;
  endfunction

  task automatic check_grid(input int tn, input int mode);
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 11; c++) begin
        chk($sformatf("t%0d u0 cell[%0d][%0d]", tn, r, c), 32'(num0[r][c]), exp_cell(mode, 1'b0, r, c));
        chk($sformatf("t%0d u1 cell[%0d][%0d]", tn, r, c), 32'(num1[r][c]), exp_cell(mode, 1'b1, r, c));
      end
    prev37 = 8'(exp_cell(mode, 1'b0, 3, 7));
  endtask

  // Streams a 44x44 frame; stops just before pixel (ax,ay) when that position is reached.
  task automatic send_frame(input int mode, input bit gaps, input int ax, input int ay);
    for (int y = 0; y < 44; y++)
      for (int x = 0; x < 44; x++) begin
        if (x == ax && y == ay) begin
          pix_valid = 1'b0;
          pix_sof   = 1'b0;
          return;
        end
        if (gaps) begin
          pix_valid = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
        end
        pix_valid = 1'b1;
        pix_sof   = (x == 0 && y == 0);
        pix_data  = 8'(pix_val(mode, x, y));
        if (x == 43 && y == 43) begin
          chk("grid_valid before last pixel", 32'(gv0), 0);
          chk("numero held before completion", 32'(num0[3][7]), 32'(prev37));
        end
        tick();
      end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy after start", 32'(busy0), 1);
  endtask

  // Called right after the last pixel edge; chain=1 re-arms with start in the grid_valid cycle.
  task automatic after_frame(input int tn, input int mode, input bit chain);
    chk($sformatf("t%0d u0 grid_valid", tn), 32'(gv0), 1);
    chk($sformatf("t%0d u1 grid_valid", tn), 32'(gv1), 1);
    chk($sformatf("t%0d busy in grid_valid cycle", tn), 32'(busy0), 0);
    start = chain;
    tick();
    start = 1'b0;
    chk($sformatf("t%0d grid_valid one cycle", tn), 32'(gv0), 0);
    chk($sformatf("t%0d busy after pulse", tn), 32'(busy0), 32'(chain));
    check_grid(tn, mode);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 8'd0;
    repeat (3) tick();
    chk("reset busy", 32'(busy0), 0);
    chk("reset grid_valid", 32'(gv0), 0);
    chk("reset busy inv", 32'(busy1), 0);
    check_grid(0, 3);
    reset = 1'b0;
    pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 8'd99;
    tick();
    pix_valid = 1'b0; pix_sof = 1'b0;
    chk("idle ignores pixels", 32'(busy0), 0);

    // 1: constant 200
    do_start();
    cval = 200;
    send_frame(0, 1'b0, -1, -1);
    after_frame(1, 0, 1'b1);

    // 2: cell pattern, preceded by non-sof pixels that must be ignored while waiting
    pix_valid = 1'b1; pix_data = 8'd255;
    repeat (3) tick();
    pix_valid = 1'b0;
    chk("wait_sof still busy", 32'(busy0), 1);
    send_frame(1, 1'b0, -1, -1);
    after_frame(2, 1, 1'b0);

    // 3: constant 55 (inverts to 200), then truncation frame
    do_start();
    cval = 55;
    send_frame(0, 1'b0, -1, -1);
    after_frame(3, 0, 1'b1);
    send_frame(2, 1'b0, -1, -1);
    after_frame(3, 2, 1'b0);

    // 4: cell pattern with random pix_valid gaps
    do_start();
    send_frame(1, 1'b1, -1, -1);
    after_frame(4, 1, 1'b0);

    // 5: sof reasserted at (17,9), then a full constant-90 frame
    do_start();
    gv_mark = gv_count;
    send_frame(1, 1'b0, 17, 9);
    chk("t5 no pulse on partial frame", 32'(gv0), 0);
    cval = 90;
    send_frame(0, 1'b0, -1, -1);
    after_frame(5, 0, 1'b1);
    chk("t5 single grid_valid", gv_count - gv_mark, 1);

    // 6: reset mid-capture at (30,40), then a clean capture
    send_frame(1, 1'b0, 30, 40);
    reset = 1'b1;
    tick();
    chk("t6 busy after reset", 32'(busy0), 0);
    chk("t6 grid_valid after reset", 32'(gv0), 0);
    check_grid(6, 3);
    reset = 1'b0;
    tick();
    do_start();
    send_frame(1, 1'b0, -1, -1);
    after_frame(6, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
